adc_jesd_link_seq: RTL and testbench
====================================

ADC_JESD_LINK_SEQ -- requirements
Module: adc_jesd_link_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16, cycles rst_align is held high per attempt.
REQ-002 SHALL have parameter SYNC_TIMEOUT, default 4096, max cycles in WAIT_SYNC before retry.
REQ-003 SHALL have parameter LMFC_SETTLE, default 4, lmfc_edge pulses counted with sync_n high before RUN.
REQ-004 SHALL have parameter ERR_WINDOW, default 1024, and ERR_THRESH, default 8: error-rate window length in cycles and per-window error limit.
REQ-005 SHALL have parameter MAX_RETRY, default 7, attempts before FAULT.
REQ-006 SHALL have ports, clock and reset first:
- clk_120  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  link bring-up request; level.
- xrx_syncstatus_adc  in  8  per-byte CGS sync status.
- xrx_errdetect_adc  in  8  per-byte 8b10b code error.
- xrx_disperr_adc  in  8  per-byte disparity error.
- sync_n_adc  in  1  combined aligner SYNC~ (high = synced).
- sysref_error  in  1  SYSREF/LMFC misalignment pulse.
- lmfc_edge  in  1  one-cycle LMFC boundary pulse.
- rst_adc_align  out  1  active-high reset to aligners and LMFC generator.
- link_up  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- state_o  out  3  current state code.
- retry_cnt  out  4  attempts made since last clean start.
- err_cnt  out  16  saturating total errors counted in RUN.

Function
REQ-007 States, encoded IDLE=0, RESET=1, WAIT_SYNC=2, WAIT_LMFC=3, RUN=4, FAULT=5; other codes SHALL go to IDLE next cycle.
REQ-008 IDLE: rst_adc_align=1; enable=1 -> RESET with retry_cnt=0.
REQ-009 RESET: rst_adc_align=1 for exactly RST_CYCLES cycles, then WAIT_SYNC; rst_adc_align deasserts the cycle WAIT_SYNC is entered.
REQ-010 WAIT_SYNC: advance to WAIT_LMFC when xrx_syncstatus_adc==8'hFF and sync_n_adc==1 in the same cycle; timeout counter reaching SYNC_TIMEOUT -> retry (REQ-014).
REQ-011 WAIT_LMFC: count lmfc_edge pulses while sync_n_adc==1; count reaching LMFC_SETTLE -> RUN; sync_n_adc==0 or sysref_error -> retry.
REQ-012 RUN: per cycle add popcount(xrx_errdetect_adc | xrx_disperr_adc) (0..8) to window counter and to err_cnt; err_cnt saturates at 16'hFFFF.
REQ-013 RUN: window counter reset every ERR_WINDOW cycles; window sum > ERR_THRESH, sync_n_adc==0, syncstatus!=8'hFF, or sysref_error -> retry; a window boundary and a qualifying error in the same cycle: error counted into the new window.
REQ-014 Retry: if retry_cnt==MAX_RETRY go to FAULT, else retry_cnt+1 (saturating at 15) and go to RESET.
REQ-015 Successful entry to RUN SHALL NOT clear retry_cnt; it clears only in IDLE->RESET.
REQ-016 FAULT: rst_adc_align=1, fault=1; exit to IDLE only when enable=0.
REQ-017 enable=0 in any state except IDLE SHALL go to IDLE next cycle; takes priority over all other transitions.
REQ-018 All outputs registered; state_o, link_up, fault, rst_adc_align reflect the state one cycle after the transition decision.
REQ-019 err_cnt cleared on IDLE->RESET only; held otherwise outside RUN.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force: state IDLE, rst_adc_align=1, link_up=0, fault=0, retry_cnt=0, err_cnt=0, all internal counters 0; mid-RUN reset behaves identically.

Structure
REQ-021 State encoding constants and default parameter values SHALL live in shared package jesd_rx_pkg.
REQ-022 One sub-module SHALL be used: popcnt8 (8-bit combinational popcount, 4-bit result).

Verification
REQ-023 enable=1, syncstatus=FF and sync_n=1 at cycle 20, lmfc_edge every 15 cycles -> rst_adc_align high 16 cycles, link_up=1 after 4th edge, retry_cnt=0.
REQ-024 syncstatus stuck 8'h7F -> retry every 16+4096 cycles; after 8th timeout fault=1, retry_cnt=7; enable=0 -> IDLE.
REQ-025 In RUN, errdetect=8'h03 for 5 cycles within one window (10 errors) -> retry, retry_cnt=1, err_cnt=10.
REQ-026 In RUN, 8 single-bit errors in one window and 8 in the next -> no retry, err_cnt=16.
REQ-027 sysref_error pulse in WAIT_LMFC -> RESET next cycle; rst_n=0 mid-RUN -> all outputs reset values next cycle.

Source files
------------

// File: rtl/jesd_rx_pkg.sv
// Shared state encoding, default tuning values and helpers for the JESD204B receive
// link bring-up sequencer.
package jesd_rx_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StReset    = 3'd1,
    StWaitSync = 3'd2,
    StWaitLmfc = 3'd3,
    StRun      = 3'd4,
    StFault    = 3'd5
  } link_state_e;

  localparam int unsigned RstCyclesDef   = 16;
  localparam int unsigned SyncTimeoutDef = 4096;
  localparam int unsigned LmfcSettleDef  = 4;
  localparam int unsigned ErrWindowDef   = 1024;
  localparam int unsigned ErrThreshDef   = 8;
  localparam int unsigned MaxRetryDef    = 7;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/popcnt8.sv
// Combinational population count of an 8-bit vector.
module popcnt8 (
  input  logic [7:0] din,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, din[i]};
    end
  end

endmodule

// File: rtl/adc_jesd_link_seq.sv
// ADC JESD204B link bring-up sequencer: resets the aligners, waits for CGS sync and LMFC
// settling, then watches the per-window error rate and retries the link on any loss.
module adc_jesd_link_seq
  import jesd_rx_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = RstCyclesDef,
  parameter int unsigned SYNC_TIMEOUT = SyncTimeoutDef,
  parameter int unsigned LMFC_SETTLE  = LmfcSettleDef,
  parameter int unsigned ERR_WINDOW   = ErrWindowDef,
  parameter int unsigned ERR_THRESH   = ErrThreshDef,
  parameter int unsigned MAX_RETRY    = MaxRetryDef
) (
  input  logic        clk_120,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  xrx_syncstatus_adc,
  input  logic [7:0]  xrx_errdetect_adc,
  input  logic [7:0]  xrx_disperr_adc,
  input  logic        sync_n_adc,
  input  logic        sysref_error,
  input  logic        lmfc_edge,
  output logic        rst_adc_align,
  output logic        link_up,
  output logic        fault,
  output logic [2:0]  state_o,
  output logic [3:0]  retry_cnt,
  output logic [15:0] err_cnt
);

  link_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wcyc_q, wcyc_d;
  logic [31:0] wsum_q, wsum_d, wsum_next;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] err_q, err_d;
  logic [7:0]  err_bits;
  logic [3:0]  errs;
  logic        sync_ok, retry_req;
  logic        rst_align_q, link_up_q, fault_q;

  assign err_bits = xrx_errdetect_adc | xrx_disperr_adc;
  assign sync_ok  = (xrx_syncstatus_adc == 8'hFF) && sync_n_adc;

  popcnt8 u_popcnt (
    .din(err_bits),
    .cnt(errs)
  );

  // First cycle of every window starts a fresh sum, so boundary errors land in the new window.
  assign wsum_next = (wcyc_q == 32'd0) ? {28'd0, errs} : wsum_q + {28'd0, errs};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcyc_d    = wcyc_q;
    wsum_d    = wsum_q;
    retry_d   = retry_q;
    err_d     = err_q;
    retry_req = 1'b0;
    if (!enable && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) begin
            state_d = StReset;
            cnt_d   = 32'd0;
            retry_d = 4'd0;
            err_d   = 16'd0;
          end
        end
        StReset: begin
          if (cnt_q == RST_CYCLES - 1) begin
            state_d = StWaitSync;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StWaitSync: begin
          if (sync_ok) begin
            state_d = StWaitLmfc;
            cnt_d   = 32'd0;
          end else if (cnt_q == SYNC_TIMEOUT - 1) begin
            retry_req = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StWaitLmfc: begin
          if (!sync_n_adc || sysref_error) begin
            retry_req = 1'b1;
          end else if (lmfc_edge) begin
            if (cnt_q == LMFC_SETTLE - 1) begin
              state_d = StRun;
              wcyc_d  = 32'd0;
              wsum_d  = 32'd0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        StRun: begin
          err_d  = sat_add16(err_q, errs);
          wsum_d = wsum_next;
          wcyc_d = (wcyc_q == ERR_WINDOW - 1) ? 32'd0 : wcyc_q + 32'd1;
          if ((wsum_next > ERR_THRESH) || !sync_ok || sysref_error) begin
            retry_req = 1'b1;
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
      if (retry_req) begin
        cnt_d = 32'd0;
        if (retry_q == 4'(MAX_RETRY)) begin
          state_d = StFault;
        end else begin
          state_d = StReset;
          if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_120) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 32'd0;
      wcyc_q      <= 32'd0;
      wsum_q      <= 32'd0;
      retry_q     <= 4'd0;
      err_q       <= 16'd0;
      rst_align_q <= 1'b1;
      link_up_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcyc_q      <= wcyc_d;
      wsum_q      <= wsum_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      rst_align_q <= (state_d == StIdle) || (state_d == StReset) || (state_d == StFault);
      link_up_q   <= (state_d == StRun);
      fault_q     <= (state_d == StFault);
    end
  end

  assign rst_adc_align = rst_align_q;
  assign link_up       = link_up_q;
  assign fault         = fault_q;
  assign state_o       = state_q;
  assign retry_cnt     = retry_q;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_adc_jesd_link_seq.sv
// Directed bench for adc_jesd_link_seq: an abstract phase/age model checked every cycle,
// plus hand-computed checkpoints for bring-up, error windows, retries, fault and reset.
module tb_adc_jesd_link_seq;

  localparam int RST_CYCLES   = 16;
  localparam int SYNC_TIMEOUT = 4096;
  localparam int LMFC_SETTLE  = 4;
  localparam int ERR_WINDOW   = 1024;
  localparam int ERR_THRESH   = 8;
  localparam int MAX_RETRY    = 7;

  localparam int S_IDLE = 0, S_RESET = 1, S_WSYNC = 2, S_WLMFC = 3, S_RUN = 4, S_FAULT = 5;

  logic        clk_120 = 1'b0;
  logic        rst_n, enable, sync_n_adc, sysref_error, lmfc_edge;
  logic [7:0]  xrx_syncstatus_adc, xrx_errdetect_adc, xrx_disperr_adc;
  logic        rst_adc_align, link_up, fault;
  logic [2:0]  state_o;
  logic [3:0]  retry_cnt;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: current phase, cycles spent in it, LMFC edges seen, and RUN error bookkeeping.
  int m_st, m_age, m_edges, m_retry, m_err, m_run_age, m_wsum, m_nxt, m_e;
  bit model_valid = 1'b0;

  always #5 clk_120 = ~clk_120;

  adc_jesd_link_seq #(
    .RST_CYCLES  (RST_CYCLES),
    .SYNC_TIMEOUT(SYNC_TIMEOUT),
    .LMFC_SETTLE (LMFC_SETTLE),
    .ERR_WINDOW  (ERR_WINDOW),
    .ERR_THRESH  (ERR_THRESH),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk_120           (clk_120),
    .rst_n             (rst_n),
    .enable            (enable),
    .xrx_syncstatus_adc(xrx_syncstatus_adc),
    .xrx_errdetect_adc (xrx_errdetect_adc),
    .xrx_disperr_adc   (xrx_disperr_adc),
    .sync_n_adc        (sync_n_adc),
    .sysref_error      (sysref_error),
    .lmfc_edge         (lmfc_edge),
    .rst_adc_align     (rst_adc_align),
    .link_up           (link_up),
    .fault             (fault),
    .state_o           (state_o),
    .retry_cnt         (retry_cnt),
    .err_cnt           (err_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_120) begin
    if (!rst_n) begin
      m_st = S_IDLE; m_age = 0; m_edges = 0; m_retry = 0; m_err = 0;
      m_run_age = 0; m_wsum = 0;
      model_valid = 1'b1;
    end else if (!enable && m_st != S_IDLE) begin
      m_st = S_IDLE;
      m_age = 0;
    end else begin
      m_nxt = m_st;
      case (m_st)
        S_IDLE: if (enable) begin m_nxt = S_RESET; m_retry = 0; m_err = 0; end
        S_RESET: if (m_age + 1 == RST_CYCLES) m_nxt = S_WSYNC;
        S_WSYNC: begin
          if (xrx_syncstatus_adc == 8'hFF && sync_n_adc) m_nxt = S_WLMFC;
          else if (m_age + 1 == SYNC_TIMEOUT) m_nxt = -1;
        end
        S_WLMFC: begin
          if (!sync_n_adc || sysref_error) m_nxt = -1;
          else if (lmfc_edge) begin
            m_edges++;
            if (m_edges == LMFC_SETTLE) m_nxt = S_RUN;
          end
        end
        S_RUN: begin
          m_e = $countones(xrx_errdetect_adc | xrx_disperr_adc);
          if (m_run_age % ERR_WINDOW == 0) m_wsum = 0;
          m_wsum += m_e;
          m_err = (m_err + m_e > 65535) ? 65535 : m_err + m_e;
          m_run_age++;
          if (m_wsum > ERR_THRESH || xrx_syncstatus_adc != 8'hFF || !sync_n_adc || sysref_error)
            m_nxt = -1;
        end
        S_FAULT: ;
        default: m_nxt = S_IDLE;
      endcase
      if (m_nxt == -1) begin
        if (m_retry == MAX_RETRY) m_nxt = S_FAULT;
        else begin
          m_nxt = S_RESET;
          if (m_retry < 15) m_retry++;
        end
      end
      if (m_nxt != m_st) begin
        m_age = 0; m_edges = 0; m_run_age = 0;
      end else begin
        m_age++;
      end
      m_st = m_nxt;
    end
  end

  always @(negedge clk_120) begin
    if (model_valid) begin
      chk("state_o", int'(state_o), m_st);
      chk("rst_adc_align", int'(rst_adc_align),
          (m_st == S_IDLE || m_st == S_RESET || m_st == S_FAULT) ? 1 : 0);
      chk("link_up", int'(link_up), (m_st == S_RUN) ? 1 : 0);
      chk("fault", int'(fault), (m_st == S_FAULT) ? 1 : 0);
      chk("retry_cnt", int'(retry_cnt), m_retry);
      chk("err_cnt", int'(err_cnt), m_err);
    end
  end

  // Inputs change on the falling edge; outputs seen here reflect the previous rising edge.
  task automatic drive(input logic en, input logic [7:0] ss, input logic sn,
                       input logic [7:0] ed, input logic [7:0] dp, input logic sr);
    @(negedge clk_120);
    enable             = en;
    xrx_syncstatus_adc = ss;
    sync_n_adc         = sn;
    xrx_errdetect_adc  = ed;
    xrx_disperr_adc    = dp;
    sysref_error       = sr;
    lmfc_edge          = (cyc % 15 == 14);
    cyc++;
  endtask

  task automatic bring_up();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
      if (link_up) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bring_up_link", int'(ok), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_rst_align"}, int'(rst_adc_align), 1);
    chk({tag, "_link_up"}, int'(link_up), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_retry"}, int'(retry_cnt), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
  endtask

  initial begin
    int n_reset, first_up, first_fault, n_retry, prev_state;
    bit seen;
    rst_n = 1'b0; enable = 1'b0; sync_n_adc = 1'b0; sysref_error = 1'b0; lmfc_edge = 1'b0;
    xrx_syncstatus_adc = 8'h00; xrx_errdetect_adc = 8'h00; xrx_disperr_adc = 8'h00;
    repeat (3) drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    check_reset_values("por");
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);

    // Nominal bring-up: sync at cycle 20, LMFC edges every 15 cycles.
    cyc = 0; n_reset = 0; first_up = -1;
    for (int c = 0; c < 80; c++) begin
      drive(1'b1, (c >= 20) ? 8'hFF : 8'h00, (c >= 20), 8'h00, 8'h00, 1'b0);
      if (state_o == 3'd1) n_reset++;
      if (c == 16) chk("rst_align_last_reset_cycle", int'(rst_adc_align), 1);
      if (c == 17) begin
        chk("state_after_reset", int'(state_o), 2);
        chk("rst_align_in_wait_sync", int'(rst_adc_align), 0);
      end
      if (link_up && first_up < 0) first_up = c - 1;
    end
    chk("reset_cycles", n_reset, 16);
    chk("first_link_up_cycle", first_up, 74);
    chk("bringup_retry_cnt", int'(retry_cnt), 0);

    // Ten errors inside one window: 0x03 for five RUN cycles (ages 15..19).
    for (int a = 5; a < 20; a++) drive(1'b1, 8'hFF, 1'b1, (a >= 15) ? 8'h03 : 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("burst_state", int'(state_o), 1);
    chk("burst_retry_cnt", int'(retry_cnt), 1);
    chk("burst_err_cnt", int'(err_cnt), 10);
    chk("burst_link_up", int'(link_up), 0);

    // Eight errors at the end of window 0 and eight at the start of window 1.
    drive(1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("disable_to_idle", int'(state_o), 0);
    bring_up();
    for (int a = 1; a <= 1040; a++) begin
      drive(1'b1, 8'hFF, 1'b1, (a >= 1016 && a <= 1023) ? 8'h01 : 8'h00,
            (a >= 1016 && a <= 1023) ? 8'h01 : ((a >= 1024 && a <= 1031) ? 8'h80 : 8'h00),
            1'b0);
    end
    chk("window_state", int'(state_o), 4);
    chk("window_link_up", int'(link_up), 1);
    chk("window_retry_cnt", int'(retry_cnt), 0);
    chk("window_err_cnt", int'(err_cnt), 16);

    // SYSREF error while settling on LMFC edges.
    drive(1'b0, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
      if (state_o == 3'd3) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached_wait_lmfc", int'(seen), 1);
    drive(1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("sysref_state", int'(state_o), 1);
    chk("sysref_retry_cnt", int'(retry_cnt), 1);

    // Synchronous reset in the middle of RUN.
    bring_up();
    for (int a = 1; a <= 3; a++) drive(1'b1, 8'hFF, 1'b1, 8'h01, 8'h00, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("pre_reset_err_cnt", int'(err_cnt), 3);
    chk("pre_reset_link_up", int'(link_up), 1);
    rst_n = 1'b0;
    drive(1'b1, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0);
    check_reset_values("mid_run_reset");
    enable = 1'b0;
    rst_n  = 1'b1;

    // Sync never completes: eight timeouts lead to FAULT.
    first_fault = -1; n_retry = 0; prev_state = int'(state_o);
    for (int c = 0; c < 34000; c++) begin
      drive(1'b1, 8'h7F, 1'b1, 8'h00, 8'h00, 1'b0);
      if (prev_state == 2 && state_o == 3'd1) n_retry++;
      prev_state = int'(state_o);
      if (fault) begin
        first_fault = c - 1;
        break;
      end
    end
    chk("fault_cycle", first_fault, 32896);
    chk("timeout_retries", n_retry, 7);
    chk("fault_retry_cnt", int'(retry_cnt), 7);
    chk("fault_rst_align", int'(rst_adc_align), 1);
    chk("fault_state", int'(state_o), 5);
    drive(1'b1, 8'h7F, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("fault_held", int'(fault), 1);
    drive(1'b0, 8'h7F, 1'b1, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 8'h7F, 1'b1, 8'h00, 8'h00, 1'b0);
    chk("fault_exit_state", int'(state_o), 0);
    chk("fault_exit_fault", int'(fault), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
